controle_vedacao: RTL

//   Corking-station controller, directly downstream of the cork tray (bandeja). Detects a bottle at the

---
 rtl/controle_vedacao_pkg.sv | 22 ++
 rtl/controle_vedacao_if.sv | 21 ++
 rtl/controle_vedacao_temporizador_ciclos.sv | 25 ++
 rtl/controle_vedacao.sv | 136 +++++++++++++
 4 files changed

// File: rtl/controle_vedacao_pkg.sv
// Shared types and constants for the corking-station controller.
package controle_vedacao_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPedir   = 3'd1,
        StVedar   = 3'd2,
        StLiberar = 3'd3,
        StReabast = 3'd4,
        StParado  = 3'd5
    } estado_t;

    localparam int unsigned ROLHAS_POR_PACOTE = 20;
    localparam int unsigned T_VEDAR_PADRAO    = 3;
    localparam int unsigned T_REABAST_PADRAO  = 2;

    function automatic int unsigned maior(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controle_vedacao_if.sv
// Link between the corking controller and the cork tray (bandeja).
interface controle_vedacao_if;
    logic CR;             // tray: five corks left
    logic BZ;             // tray: zero corks left
    logic consumir_rolha; // controller: take one cork
    logic reabastecer;    // controller: load a full pack

    modport master (
        input  CR,
        input  BZ,
        output consumir_rolha,
        output reabastecer
    );

    modport slave (
        output CR,
        output BZ,
        input  consumir_rolha,
        input  reabastecer
    );
endinterface

// File: rtl/controle_vedacao_temporizador_ciclos.sv
// Loadable down-counter shared by the sealing and refill phases.
module controle_vedacao_temporizador_ciclos #(
    parameter int unsigned LARGURA = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LARGURA-1:0] valor,
    output logic               zero
);
    logic [LARGURA-1:0] contagem;

    // Load a new count or count down to zero and hold there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);
endmodule

// File: rtl/controle_vedacao.sv
// Corking-station controller: seals one bottle per arrival, refills the tray from pack stock,
// stops the line when tray and stock are both empty.
module controle_vedacao
    import controle_vedacao_pkg::*;
#(
    parameter int unsigned T_VEDAR     = T_VEDAR_PADRAO,
    parameter int unsigned T_REABAST   = T_REABAST_PADRAO,
    parameter int unsigned ESTOQUE_W   = 3,
    parameter int unsigned ESTOQUE_INI = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    controle_vedacao_if.master   bandeja,
    input  logic                 sensor_vedacao,
    input  logic                 repor_estoque,
    output logic                 atuador_vedacao,
    output logic                 esteira_liberada,
    output logic                 alarme_rolhas,
    output logic                 estoque_vazio,
    output logic [ESTOQUE_W-1:0] estoque
);
    localparam int unsigned TW = $clog2(maior(T_VEDAR, T_REABAST) + 1);
    // Timer counts down to zero inclusive, so load the phase length minus one
    localparam logic [TW-1:0]        CARGA_VEDAR   = TW'(T_VEDAR - 1);
    localparam logic [TW-1:0]        CARGA_REABAST = TW'(T_REABAST - 1);
    localparam logic [ESTOQUE_W-1:0] ESTOQUE_MAX   = '1;
    localparam logic [ESTOQUE_W-1:0] ESTOQUE_RST   = ESTOQUE_W'(ESTOQUE_INI);

    estado_t                estado, estado_d;
    logic                   sensor_q, pendente;
    logic                   sensor_rise, quer_pedir, tem_estoque;
    logic                   entra_reabast, entra_pedir, sai_reabast;
    logic                   carga_timer, timer_zero;
    logic [TW-1:0]          valor_timer;
    logic [ESTOQUE_W-1:0]   estoque_d;

    assign sensor_rise   = sensor_vedacao & ~sensor_q;
    // A bottle that arrived while refilling is still served if it is still there
    assign quer_pedir    = sensor_rise | (pendente & sensor_vedacao);
    assign tem_estoque   = (estoque != '0);
    assign entra_reabast = ((estado == StIdle) & bandeja.BZ & tem_estoque) |
                           ((estado == StParado) & tem_estoque);
    assign entra_pedir   = (estado == StIdle) & ~bandeja.BZ & quer_pedir;
    assign sai_reabast   = (estado == StReabast) & timer_zero;
    assign carga_timer   = (estado == StPedir) | entra_reabast;
    assign valor_timer   = (estado == StPedir) ? CARGA_VEDAR : CARGA_REABAST;

    controle_vedacao_temporizador_ciclos #(
        .LARGURA (TW)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .load  (carga_timer),
        .valor (valor_timer),
        .zero  (timer_zero)
    );

    // Next-state selection, top-down priority within each state
    always_comb begin
        estado_d = estado;
        case (estado)
            StIdle: begin
                if (bandeja.BZ) begin
                    estado_d = tem_estoque ? StReabast : StParado;
                end else if (quer_pedir) begin
                    estado_d = StPedir;
                end
            end
            StPedir:   estado_d = StVedar;
            StVedar:   if (timer_zero) estado_d = StLiberar;
            StLiberar: if (!sensor_vedacao) estado_d = StIdle;
            StReabast: if (timer_zero) estado_d = StIdle;
            StParado:  if (tem_estoque) estado_d = StReabast;
            default:   estado_d = StIdle;
        endcase
    end

    // Stock: refill entry and operator top-up cancel out when coincident
    always_comb begin
        estoque_d = estoque;
        if (entra_reabast && !repor_estoque) begin
            estoque_d = estoque - 1'b1;
        end else if (!entra_reabast && repor_estoque && (estoque != ESTOQUE_MAX)) begin
            estoque_d = estoque + 1'b1;
        end
    end

    // Sensor edge register and unserved-arrival flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sensor_q <= 1'b0;
            pendente <= 1'b0;
        end else begin
            sensor_q <= sensor_vedacao;
            if (entra_pedir) begin
                pendente <= 1'b0;
            end else if (sensor_rise) begin
                pendente <= 1'b1;
            end
        end
    end

    // FSM state with outputs registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado                 <= StIdle;
            bandeja.consumir_rolha <= 1'b0;
            bandeja.reabastecer    <= 1'b0;
            atuador_vedacao        <= 1'b0;
            esteira_liberada       <= 1'b1;
            alarme_rolhas          <= 1'b0;
        end else begin
            estado                 <= estado_d;
            bandeja.consumir_rolha <= (estado_d == StPedir);
            bandeja.reabastecer    <= (estado_d == StReabast);
            atuador_vedacao        <= (estado_d == StVedar);
            esteira_liberada       <= (estado_d == StIdle) || (estado_d == StLiberar);
            if (sai_reabast) begin
                alarme_rolhas <= 1'b0;
            end else if (bandeja.CR || bandeja.BZ || (estado_d == StParado)) begin
                alarme_rolhas <= 1'b1;
            end
        end
    end

    // Pack stock counter and its empty flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estoque       <= ESTOQUE_RST;
            estoque_vazio <= (ESTOQUE_RST == '0);
        end else begin
            estoque       <= estoque_d;
            estoque_vazio <= (estoque_d == '0);
        end
    end
endmodule
